lab3_cache_mem_line_assembler: RTL and testbench
================================================

// Module: lab3_cache_mem_line_assembler
// PURPOSE
//  Parametrised memory-response line assembler for the lab3 cache refill path.
//  Collects NWORDS words of WORD_BW bits from a val/rdy word stream into one cache line,
//  then presents the line on a val/rdy output. Supports critical-word-first (wrapped) fill.
//  Holds a new line's first word in the same cycle the previous line drains, so back-to-back refills need no bubble.
// PARAMETERS
//  WORD_BW   32  bits per incoming word
//  NWORDS    16  words per line; power of 2, >= 2
//  OFF_BW    $clog2(NWORDS)  word-offset width (derived; do not override)
// PORTS
//  clk            in   1                  clock, rising edge
//  reset          in   1                  asynchronous, active-low (0 = reset)
//  istream_val    in   1                  input word valid
//  istream_rdy    out  1                  input word ready
//  istream_msg    in   WORD_BW            input word
//  start_off      in   OFF_BW             line slot of the first word; sampled only on the first word of a line
//  ostream_val    out  1                  assembled line valid
//  ostream_rdy    in   1                  downstream ready
//  mem_data       out  WORD_BW*NWORDS     assembled line; word i at [i*WORD_BW +: WORD_BW]
//  crit_val       out  1                  only with CMR_CRIT_WORD_EN
//  crit_word      out  WORD_BW            only with CMR_CRIT_WORD_EN
// BEHAVIOUR
//  - Reset (reset==0, asynchronous): state=FILL, cnt=0, ptr=0, line regs=0, ostream_val=0.
//    istream_rdy is forced 0 while reset is low. A reset mid-line discards the partial line.
//  - States: FILL (collecting words), FULL (line held, ostream_val=1).
//  - istream_rdy = (state==FILL) | (state==FULL & ostream_rdy).
//  - Word accept (istream_val & istream_rdy):
//    - First word of a line (cnt==0): written to slot start_off; ptr <= start_off+1 mod NWORDS.
//    - Later words: written to slot ptr; ptr increments mod NWORDS, wrapping from NWORDS-1 to 0.
//    - cnt increments on every accepted word.
//  - FILL->FULL on the accept that makes cnt==NWORDS; cnt then clears to 0.
//    ostream_val rises the next cycle, so latency is 1 cycle from the last word to ostream_val.
//  - FULL->FILL on ostream_val & ostream_rdy. mem_data is stable while ostream_val=1.
//  - Simultaneous drain and accept in FULL: the line is handed off and the incoming word is
//    the first word of the next line (uses start_off). Next-line slots not yet written
//    read as stale data (not zeroed).
//  - Words never overwrite a held line: in FULL, no write occurs unless ostream_rdy=1.
//  - Ignores istream_msg/start_off when there is no handshake. ostream_rdy is don't-care in FILL.
// CONFIGURATION
//  CMR_CRIT_WORD_EN defined:
//    - crit_val pulses 1 for exactly one cycle, the cycle after the first word of each line
//      is accepted. crit_word = that word, held until the next first-word accept.
//    - crit_val=0 and crit_word=0 at reset.
//  CMR_CRIT_WORD_EN undefined:
//    - crit_val/crit_word ports and their logic are absent. All other behaviour is identical.
// TESTING
//  1. Default params, start_off=0, words 0x0..0xF with ostream_rdy=1:
//     -> 1 cycle after word 0xF, ostream_val=1 and mem_data word i == i; drains that cycle.
//  2. start_off=5, words 0xA0..0xAF:
//     -> slot 5=0xA0, slot 15=0xAA, slot 0=0xAB, slot 4=0xAF (wrap checked).
//  3. Hold ostream_rdy=0 for 10 cycles after a full line:
//     -> istream_rdy=0 and mem_data unchanged; raising ostream_rdy drains and accepts the next word in the same cycle.
//  4. Back-to-back lines of 16x0x4 then 8x0x1 + 8x0x4, ostream_rdy=1:
//     -> two lines, no bubble; second line's low 8 words=0x1, high 8 words=0x4.
//  5. Drop reset to 0 after 7 words, then resend a full line:
//     -> ostream_val=0 immediately; the new line assembles correctly with no leftover words.
//  6. CMR_CRIT_WORD_EN, start_off=3, first word 0xDEADBEEF:
//     -> next cycle crit_val=1, crit_word=0xDEADBEEF; crit_val=0 the following cycle.
//  Also rerun tests 1-5 with WORD_BW=64, NWORDS=4.

Source files
------------

// File: rtl/lab3_cache_mem_line_assembler_if.sv
// Word-stream in / assembled-line out bus for the lab3 cache refill line assembler.
// Crit-word signals exist only when CMR_CRIT_WORD_EN is defined.
interface lab3_cache_mem_line_assembler_if #(
  parameter int WORD_BW = 32,
  parameter int NWORDS  = 16
);
  localparam int OFF_BW = $clog2(NWORDS);

  logic                      istream_val;
  logic                      istream_rdy;
  logic [WORD_BW-1:0]        istream_msg;
  logic [OFF_BW-1:0]         start_off;
  logic                      ostream_val;
  logic                      ostream_rdy;
  logic [WORD_BW*NWORDS-1:0] mem_data;
`ifdef CMR_CRIT_WORD_EN
  logic                      crit_val;
  logic [WORD_BW-1:0]        crit_word;
`endif

  modport slave (
    input  istream_val, istream_msg, start_off, ostream_rdy,
    output istream_rdy, ostream_val, mem_data
`ifdef CMR_CRIT_WORD_EN
    , output crit_val, crit_word
`endif
  );

  modport master (
    output istream_val, istream_msg, start_off, ostream_rdy,
    input  istream_rdy, ostream_val, mem_data
`ifdef CMR_CRIT_WORD_EN
    , input crit_val, crit_word
`endif
  );
endinterface

// File: rtl/lab3_cache_mem_line_assembler.sv
// Refill line assembler: gathers NWORDS words (wrapped, critical-word-first) into one line.
// Optional feature macro: CMR_CRIT_WORD_EN adds crit_val/crit_word.
module lab3_cache_mem_line_assembler #(
  parameter int WORD_BW = 32,
  parameter int NWORDS  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  lab3_cache_mem_line_assembler_if.slave io
);
  localparam int OFF_BW = $clog2(NWORDS);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]         state;
  logic [OFF_BW-1:0]  cnt;
  logic [OFF_BW-1:0]  ptr;
  logic [OFF_BW-1:0]  wslot;
  logic [WORD_BW-1:0] line_q [NWORDS];
  logic               accept;
  logic               drain;
  logic               first;
  logic               last;

  // Ready also while draining so the next line's first word lands without a bubble.
  assign io.istream_rdy = reset & ((state == FILL) | ((state == FULL) & io.ostream_rdy));
  assign io.ostream_val = (state == FULL);

  assign accept = io.istream_val & io.istream_rdy;
  assign drain  = (state == FULL) & io.ostream_rdy;
  assign first  = (cnt == '0);
  assign last   = (cnt == OFF_BW'(NWORDS - 1));
  assign wslot  = first ? io.start_off : ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      cnt   <= '0;
      ptr   <= '0;
      for (int unsigned i = 0; i < NWORDS; i++) line_q[i] <= '0;
    end else begin
      if (accept) begin
        line_q[wslot] <= io.istream_msg;
        ptr           <= wslot + 1'b1;
        // cnt is OFF_BW wide, so it wraps to 0 on the line-completing word
        cnt           <= cnt + 1'b1;
      end
      if (accept && last)
        state <= FULL;
      else if (drain)
        state <= FILL;
    end
  end

  for (genvar g = 0; g < NWORDS; g++) begin : g_pack
    assign io.mem_data[g*WORD_BW +: WORD_BW] = line_q[g];
  end

`ifdef CMR_CRIT_WORD_EN
  logic               crit_val_q;
  logic [WORD_BW-1:0] crit_word_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crit_val_q  <= 1'b0;
      crit_word_q <= '0;
    end else begin
      crit_val_q <= accept & first;
      if (accept && first) crit_word_q <= io.istream_msg;
    end
  end

  assign io.crit_val  = crit_val_q;
  assign io.crit_word = crit_word_q;
`endif
endmodule

// File: tb/tb_lab3_cache_mem_line_assembler.sv
// Scoreboard bench for lab3_cache_mem_line_assembler: lines predicted on word accept, compared on drain.
module tb_lab3_cache_mem_line_assembler;
  parameter int WORD_BW = 32;
  parameter int NWORDS  = 16;
  localparam int OFF_BW = $clog2(NWORDS);
  localparam int MD_BW  = WORD_BW * NWORDS;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lab3_cache_mem_line_assembler_if #(.WORD_BW(WORD_BW), .NWORDS(NWORDS)) ifc ();

  lab3_cache_mem_line_assembler #(.WORD_BW(WORD_BW), .NWORDS(NWORDS)) dut (
    .clk   (clk),
    .reset (rst_n),
    .io    (ifc.slave)
  );

  task automatic check(input string tag, input logic [MD_BW-1:0] got, input logic [MD_BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model of the line being assembled and the queue of predicted lines
  logic [WORD_BW-1:0] m_line [NWORDS];
  logic [OFF_BW-1:0]  m_ptr;
  int                 m_cnt;
  logic [MD_BW-1:0]   exp_q [$];

  function automatic logic [MD_BW-1:0] pack_line();
    logic [MD_BW-1:0] v;
    for (int i = 0; i < NWORDS; i++) v[i*WORD_BW +: WORD_BW] = m_line[i];
    return v;
  endfunction

  always @(negedge clk) begin
    logic [OFF_BW-1:0] slot;
    if (!rst_n) begin
      m_cnt = 0;
      m_ptr = '0;
      for (int i = 0; i < NWORDS; i++) m_line[i] = '0;
      exp_q.delete();
    end else begin
      if (ifc.ostream_val && ifc.ostream_rdy) begin
        if (exp_q.size() == 0) check("spurious_line", MD_BW'(1), MD_BW'(0));
        else                   check("line", ifc.mem_data, exp_q.pop_front());
      end
      if (ifc.istream_val && ifc.istream_rdy) begin
        slot         = (m_cnt == 0) ? ifc.start_off : m_ptr;
        m_line[slot] = ifc.istream_msg;
        m_ptr        = OFF_BW'(slot + 1);
        m_cnt++;
        if (m_cnt == NWORDS) begin
          m_cnt = 0;
          exp_q.push_back(pack_line());
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send_word(input logic [WORD_BW-1:0] w, input logic [OFF_BW-1:0] so);
    int n = 0;
    ifc.istream_val = 1'b1;
    ifc.istream_msg = w;
    ifc.start_off   = so;
    @(negedge clk);
    while (!ifc.istream_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.istream_rdy) check("send_timeout", MD_BW'(0), MD_BW'(1));
    @(posedge clk);
    #1;
    ifc.istream_val = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [MD_BW-1:0]   held;
    logic [OFF_BW-1:0]  s0;
    int unsigned        c0;
    int                 ks [4];

    rst_n           = 1'b0;
    ifc.istream_val = 1'b0;
    ifc.istream_msg = '0;
    ifc.start_off   = '0;
    ifc.ostream_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_istream_rdy", MD_BW'(ifc.istream_rdy), MD_BW'(0));
    check("rst_ostream_val", MD_BW'(ifc.ostream_val), MD_BW'(0));
    check("rst_mem_data", ifc.mem_data, '0);
`ifdef CMR_CRIT_WORD_EN
    check("rst_crit_val", MD_BW'(ifc.crit_val), MD_BW'(0));
    check("rst_crit_word", MD_BW'(ifc.crit_word), MD_BW'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_istream_rdy", MD_BW'(ifc.istream_rdy), MD_BW'(1));
    @(posedge clk);
    #1;

    // Test 1: in-order fill, immediate drain
    ifc.ostream_rdy = 1'b1;
    for (int i = 0; i < NWORDS; i++) send_word(WORD_BW'(i), '0);
    check("t1_ostream_val", MD_BW'(ifc.ostream_val), MD_BW'(1));
    for (int i = 0; i < NWORDS; i++)
      check("t1_word", MD_BW'(ifc.mem_data[i*WORD_BW +: WORD_BW]), MD_BW'(i));
    @(posedge clk);
    #1;
    check("t1_drained", MD_BW'(ifc.ostream_val), MD_BW'(0));

    // Test 2: wrapped fill from slot 5; later start_off values must be ignored
    ifc.ostream_rdy = 1'b0;
    s0 = OFF_BW'(5);
    for (int i = 0; i < NWORDS; i++)
      send_word(WORD_BW'('hA0 + i), (i == 0) ? s0 : OFF_BW'($urandom));
    check("t2_ostream_val", MD_BW'(ifc.ostream_val), MD_BW'(1));
    ks = '{0, NWORDS - 1 - int'(s0), NWORDS - int'(s0), NWORDS - 1};
    foreach (ks[j])
      check("t2_slot", MD_BW'(ifc.mem_data[((int'(s0) + ks[j]) % NWORDS)*WORD_BW +: WORD_BW]),
            MD_BW'('hA0 + ks[j]));

    // Test 3: back-pressure holds the line; a pending word must not overwrite it
    held            = ifc.mem_data;
    ifc.istream_val = 1'b1;
    ifc.istream_msg = WORD_BW'('h55);
    ifc.start_off   = OFF_BW'(2);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("t3_istream_rdy", MD_BW'(ifc.istream_rdy), MD_BW'(0));
      check("t3_ostream_val", MD_BW'(ifc.ostream_val), MD_BW'(1));
      check("t3_mem_stable", ifc.mem_data, held);
    end
    ifc.ostream_rdy = 1'b1;
    #1;
    check("t3_rdy_on_drain", MD_BW'(ifc.istream_rdy), MD_BW'(1));
    @(posedge clk);
    #1;
    check("t3_drained", MD_BW'(ifc.ostream_val), MD_BW'(0));
    ifc.istream_val = 1'b0;
    for (int i = 1; i < NWORDS; i++) send_word(WORD_BW'('h60 + i), '0);

    // Test 4: back-to-back lines with no bubble
    c0 = cyc;
    for (int i = 0; i < NWORDS; i++) send_word(WORD_BW'('h4), '0);
    for (int i = 0; i < NWORDS; i++) send_word((i < NWORDS / 2) ? WORD_BW'('h1) : WORD_BW'('h4), '0);
    check("t4_cycles", MD_BW'(cyc - c0), MD_BW'(2 * NWORDS));
    check("t4_ostream_val", MD_BW'(ifc.ostream_val), MD_BW'(1));
    for (int i = 0; i < NWORDS; i++)
      check("t4_word", MD_BW'(ifc.mem_data[i*WORD_BW +: WORD_BW]),
            (i < NWORDS / 2) ? MD_BW'('h1) : MD_BW'('h4));
    @(posedge clk);
    #1;

    // Test 5: reset mid-line discards the partial line
    for (int i = 0; i < 7; i++) send_word(WORD_BW'('h90 + i), '0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_ostream_val", MD_BW'(ifc.ostream_val), MD_BW'(0));
    check("t5_istream_rdy", MD_BW'(ifc.istream_rdy), MD_BW'(0));
    check("t5_mem_cleared", ifc.mem_data, '0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NWORDS - 1; i++) begin
      send_word(WORD_BW'('h70 + i), OFF_BW'(3));
      check("t5_no_early_line", MD_BW'(ifc.ostream_val), MD_BW'(0));
    end
    send_word(WORD_BW'('h70 + NWORDS - 1), '0);
    check("t5_ostream_val_full", MD_BW'(ifc.ostream_val), MD_BW'(1));
    for (int i = 0; i < NWORDS; i++)
      check("t5_word", MD_BW'(ifc.mem_data[((3 + i) % NWORDS)*WORD_BW +: WORD_BW]),
            MD_BW'('h70 + i));
    @(posedge clk);
    #1;

`ifdef CMR_CRIT_WORD_EN
    // Test 6: critical word pulse and hold
    send_word(WORD_BW'(32'hDEADBEEF), OFF_BW'(3));
    check("t6_crit_val", MD_BW'(ifc.crit_val), MD_BW'(1));
    check("t6_crit_word", MD_BW'(ifc.crit_word), MD_BW'(WORD_BW'(32'hDEADBEEF)));
    @(posedge clk);
    #1;
    check("t6_crit_val_off", MD_BW'(ifc.crit_val), MD_BW'(0));
    for (int i = 1; i < NWORDS; i++) send_word(WORD_BW'('h10 + i), '0);
    check("t6_crit_word_held", MD_BW'(ifc.crit_word), MD_BW'(WORD_BW'(32'hDEADBEEF)));
    check("t6_crit_val_quiet", MD_BW'(ifc.crit_val), MD_BW'(0));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("pending_lines", MD_BW'(exp_q.size()), MD_BW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
